// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of the sequencer: hazard controls, instruction memory
// port and the IF/ID outputs toward decode.
interface fetch_sequencer_if;
    logic       stall;
    logic       flush;
    logic [7:0] flush_pc;
    logic [7:0] instr_in;
    logic [7:0] pc;
    logic       ir_en;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       has_imm;

    modport master (
        input  stall, flush, flush_pc, instr_in,
        output pc, ir_en, instr_out, instr_valid, has_imm
    );

    modport slave (
        output stall, flush, flush_pc, instr_in,
        input  pc, ir_en, instr_out, instr_valid, has_imm
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: PC, IF/ID latch, two-word (LDM/LDD/STD) pairing.
// Optional FETCH_STATS_EN adds issued/bubble saturating counters.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [3:0] TWO_WORD_OP = 4'hC,
    parameter logic [7:0] NOP_WORD    = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FETCH_STATS_EN
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_bubbles,
`endif
    fetch_sequencer_if.master bus
);

    typedef enum logic {FETCH = 1'b0, IMM = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] instr_q, instr_d;
    logic       valid_q, valid_d;
    logic       imm_q, imm_d;
    logic       is2w;

    assign is2w = (bus.instr_in[7:4] == TWO_WORD_OP) &&
                  (bus.instr_in[3:2] != 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = FETCH;
        end else if (!bus.stall) begin
            unique case (state_q)
                FETCH: state_d = is2w ? IMM : FETCH;
                IMM:   state_d = FETCH;
            endcase
        end
    end

    // The opcode of a two-word pair is parked in pend_q and only issued
    // on the edge that captures its immediate, so both reach decode together.
    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        imm_d     = imm_q;
        bus.ir_en = 1'b0;
        if (bus.flush) begin
            pc_d    = bus.flush_pc;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            imm_d   = 1'b0;
        end else if (!bus.stall) begin
            pc_d = pc_q + 8'd1;
            unique case (state_q)
                FETCH: begin
                    imm_d = 1'b0;
                    if (is2w) begin
                        pend_d  = bus.instr_in;
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = bus.instr_in;
                        valid_d = 1'b1;
                    end
                end
                IMM: begin
                    bus.ir_en = 1'b1;
                    instr_d   = pend_q;
                    valid_d   = 1'b1;
                    imm_d     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            pend_q  <= NOP_WORD;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            imm_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            imm_q   <= imm_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.has_imm     = imm_q;

`ifdef FETCH_STATS_EN
    logic [15:0] issued_q, issued_d;
    logic [15:0] bubbles_q, bubbles_d;
    logic        issue_ev, bubble_ev;

    always_comb begin
        issue_ev  = !bus.flush && !bus.stall &&
                    ((state_q == IMM) || !is2w);
        bubble_ev = bus.flush ||
                    (!bus.stall && (state_q == FETCH) && is2w);
        issued_d  = issued_q;
        bubbles_d = bubbles_q;
        if (issue_ev && issued_q != 16'hFFFF)
            issued_d = issued_q + 16'd1;
        if (bubble_ev && bubbles_q != 16'hFFFF)
            bubbles_d = bubbles_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q  <= 16'd0;
            bubbles_q <= 16'd0;
        end else begin
            issued_q  <= issued_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign stat_issued  = issued_q;
    assign stat_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a memory model and an
// external immediate register loaded by ir_en.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] mem [256];
    logic [7:0] imm_reg = 8'h00;
    int total = 0;
    int bad = 0;

    fetch_sequencer_if bus ();

`ifdef FETCH_STATS_EN
    logic [15:0] stat_issued, stat_bubbles;
`endif

    fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
`ifdef FETCH_STATS_EN
        .stat_issued  (stat_issued),
        .stat_bubbles (stat_bubbles),
`endif
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.instr_in = mem[bus.pc];

    always @(posedge clk)
        if (bus.ir_en) imm_reg <= bus.instr_in;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_pc", {8'h0, bus.pc}, 16'h0000);
        chk("rst_valid", {15'h0, bus.instr_valid}, 16'h0);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.flush_pc = 8'h00;
        mem[0] = 8'h12;
        mem[1] = 8'h34;
        #2;
        chk("r_pc", {8'h0, bus.pc}, 16'h0000);
        chk("r_out", {8'h0, bus.instr_out}, 16'h0000);
        chk("r_valid", {15'h0, bus.instr_valid}, 16'h0);
        chk("r_himm", {15'h0, bus.has_imm}, 16'h0);
        chk("r_iren", {15'h0, bus.ir_en}, 16'h0);
        #5 rst = 1'b0;

        // one-word stream
        step();
        chk("t1_pc1", {8'h0, bus.pc}, 16'h0001);
        chk("t1_out1", {8'h0, bus.instr_out}, 16'h0012);
        chk("t1_v1", {15'h0, bus.instr_valid}, 16'h1);
        chk("t1_ir1", {15'h0, bus.ir_en}, 16'h0);
        step();
        chk("t1_pc2", {8'h0, bus.pc}, 16'h0002);
        chk("t1_out2", {8'h0, bus.instr_out}, 16'h0034);
        chk("t1_ir2", {15'h0, bus.ir_en}, 16'h0);

        // LDM pair
        mem[0] = 8'hC1;
        mem[1] = 8'h42;
        mem[2] = 8'h00;
        do_reset();
        chk("t2_ir0", {15'h0, bus.ir_en}, 16'h0);
        step();
        chk("t2_v1", {15'h0, bus.instr_valid}, 16'h0);
        chk("t2_pc1", {8'h0, bus.pc}, 16'h0001);
        chk("t2_ir1", {15'h0, bus.ir_en}, 16'h1);
        step();
        chk("t2_imm", {8'h0, imm_reg}, 16'h0042);
        chk("t2_out", {8'h0, bus.instr_out}, 16'h00C1);
        chk("t2_himm", {15'h0, bus.has_imm}, 16'h1);
        chk("t2_v2", {15'h0, bus.instr_valid}, 16'h1);
        chk("t2_pc2", {8'h0, bus.pc}, 16'h0002);
        chk("t2_ir2", {15'h0, bus.ir_en}, 16'h0);

        // 0xCD is not in the two-word group
        mem[0] = 8'hCD;
        mem[1] = 8'h00;
        do_reset();
        chk("t3_ir0", {15'h0, bus.ir_en}, 16'h0);
        step();
        chk("t3_out", {8'h0, bus.instr_out}, 16'h00CD);
        chk("t3_v", {15'h0, bus.instr_valid}, 16'h1);
        chk("t3_himm", {15'h0, bus.has_imm}, 16'h0);
        chk("t3_ir", {15'h0, bus.ir_en}, 16'h0);

        // stall in IMM
        mem[0] = 8'hC5;
        mem[1] = 8'h80;
        do_reset();
        step();
        chk("t4_ir_pre", {15'h0, bus.ir_en}, 16'h1);
        bus.stall = 1'b1;
        #1;
        chk("t4_ir_st", {15'h0, bus.ir_en}, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_pc_st", {8'h0, bus.pc}, 16'h0001);
            chk("t4_ir_st2", {15'h0, bus.ir_en}, 16'h0);
            chk("t4_v_st", {15'h0, bus.instr_valid}, 16'h0);
        end
        chk("t4_imm_hold", {8'h0, imm_reg}, 16'h0042);
        bus.stall = 1'b0;
        #1;
        chk("t4_ir_rel", {15'h0, bus.ir_en}, 16'h1);
        step();
        chk("t4_imm", {8'h0, imm_reg}, 16'h0080);
        chk("t4_out", {8'h0, bus.instr_out}, 16'h00C5);
        chk("t4_himm", {15'h0, bus.has_imm}, 16'h1);
        chk("t4_pc", {8'h0, bus.pc}, 16'h0002);

        // flush with stall while in IMM
        mem[0] = 8'hC1;
        mem[1] = 8'h77;
        mem[8'h40] = 8'h12;
        do_reset();
        step();
        bus.flush = 1'b1;
        bus.flush_pc = 8'h40;
        bus.stall = 1'b1;
        #1;
        chk("t5_ir_fl", {15'h0, bus.ir_en}, 16'h0);
        step();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        #1;
        chk("t5_pc", {8'h0, bus.pc}, 16'h0040);
        chk("t5_v", {15'h0, bus.instr_valid}, 16'h0);
        chk("t5_ir", {15'h0, bus.ir_en}, 16'h0);
        chk("t5_imm", {8'h0, imm_reg}, 16'h0080);
        step();
        chk("t5_out", {8'h0, bus.instr_out}, 16'h0012);
        chk("t5_pc2", {8'h0, bus.pc}, 16'h0041);

        // two-word at 0xFF wraps for its immediate
        mem[8'hFF] = 8'hCA;
        mem[0] = 8'h90;
        bus.flush = 1'b1;
        bus.flush_pc = 8'hFF;
        step();
        bus.flush = 1'b0;
        #1;
        chk("t6_pcff", {8'h0, bus.pc}, 16'h00FF);
        step();
        chk("t6_pc0", {8'h0, bus.pc}, 16'h0000);
        chk("t6_ir", {15'h0, bus.ir_en}, 16'h1);
        step();
        chk("t6_imm", {8'h0, imm_reg}, 16'h0090);
        chk("t6_out", {8'h0, bus.instr_out}, 16'h00CA);
        chk("t6_himm", {15'h0, bus.has_imm}, 16'h1);
        chk("t6_pc1", {8'h0, bus.pc}, 16'h0001);
`ifdef FETCH_STATS_EN
        chk("st_issued", stat_issued, 16'd2);
        chk("st_bubbles", stat_bubbles, 16'd4);
`endif

        // asynchronous reset mid-pair
        mem[1] = 8'hC0;
        step();
        chk("t7_ir", {15'h0, bus.ir_en}, 16'h1);
        rst = 1'b1;
        #1;
        chk("t7_ir_rst", {15'h0, bus.ir_en}, 16'h0);
        chk("t7_pc_rst", {8'h0, bus.pc}, 16'h0000);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
